// File: rtl/repeat_matcher.sv
// repeat_matcher: streaming (PATTERN){MIN_REP,MAX_REP} detector with held match reports.
// Define REPEAT_MATCHER_CASE_FOLD_EN (CHAR_W==8 only) to compare characters ASCII case-insensitively.
module repeat_matcher #(
  parameter int CHAR_W = 8,
  parameter int PAT_LEN = 2,
  parameter logic [PAT_LEN*CHAR_W-1:0] PATTERN = 16'h6261,
  parameter int MIN_REP = 1,
  parameter int MAX_REP = 4,
  parameter int POS_W = 32,
  parameter int CNT_W = $clog2(MAX_REP+1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [CHAR_W-1:0] in_char,
  input  logic              in_last,
  output logic              in_ready,
  output logic              match_valid,
  input  logic              match_ready,
  output logic [POS_W-1:0]  match_start,
  output logic [POS_W-1:0]  match_end,
  output logic [CNT_W-1:0]  match_count
);
  localparam int IDX_W = $clog2(PAT_LEN);
  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_RUN = 1'b1;

  logic [0:0] state, n_state;
  logic [IDX_W-1:0] idx, n_idx;
  logic [CNT_W-1:0] cnt, n_cnt, cnt_inc, e_cnt;
  logic [POS_W-1:0] run_start, n_start, last_end, n_end, pos, e_start, e_end;
  logic [CHAR_W-1:0] pat [PAT_LEN];
  logic acc, m0, mi, emit;

  for (genvar g = 0; g < PAT_LEN; g++) begin : g_pat
    assign pat[g] = PATTERN[g*CHAR_W +: CHAR_W];
  end

  function automatic logic [CHAR_W-1:0] fold(input logic [CHAR_W-1:0] c);
`ifdef REPEAT_MATCHER_CASE_FOLD_EN
    return (c >= CHAR_W'(8'h41) && c <= CHAR_W'(8'h5A)) ? c + CHAR_W'(8'h20) : c;
`else
    return c;
`endif
  endfunction

  assign in_ready = !reset && (!match_valid || match_ready);
  assign acc = in_valid && in_ready;
  assign m0 = fold(in_char) == fold(pat[0]);
  assign mi = fold(in_char) == fold(pat[idx]);
  assign cnt_inc = cnt + CNT_W'(1);

  always_comb begin
    n_state = state;
    n_idx = idx;
    n_cnt = cnt;
    n_start = run_start;
    n_end = last_end;
    emit = 1'b0;
    e_start = run_start;
    e_end = last_end;
    e_cnt = cnt;
    if (state == S_IDLE) begin
      if (m0) begin
        n_state = S_RUN;
        n_start = pos;
        n_idx = IDX_W'(1);
        n_cnt = '0;
      end
    end else if (mi) begin
      n_idx = (idx == IDX_W'(PAT_LEN-1)) ? '0 : idx + IDX_W'(1);
      if (idx == IDX_W'(PAT_LEN-1)) begin
        n_cnt = cnt_inc;
        n_end = pos;
        e_end = pos;
        e_cnt = cnt_inc;
        emit = cnt_inc == CNT_W'(MAX_REP);
        n_state = emit ? S_IDLE : S_RUN;
      end
    end else begin
      // Report the completed copies, then re-test only this char as a new run start
      emit = cnt >= CNT_W'(MIN_REP);
      n_state = m0 ? S_RUN : S_IDLE;
      n_start = pos;
      n_idx = IDX_W'(1);
      n_cnt = '0;
    end
    if (in_last && !emit && n_state == S_RUN && n_cnt >= CNT_W'(MIN_REP)) begin
      emit = 1'b1;
      e_start = n_start;
      e_end = n_end;
      e_cnt = n_cnt;
    end
    if (in_last) n_state = S_IDLE;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
      idx <= '0;
      cnt <= '0;
      run_start <= '0;
      last_end <= '0;
      pos <= '0;
      match_valid <= 1'b0;
      match_start <= '0;
      match_end <= '0;
      match_count <= '0;
    end else begin
      if (acc) begin
        state <= n_state;
        idx <= n_idx;
        cnt <= n_cnt;
        run_start <= n_start;
        last_end <= n_end;
        pos <= in_last ? '0 : pos + POS_W'(1);
      end
      if (acc && emit) begin
        match_valid <= 1'b1;
        match_start <= e_start;
        match_end <= e_end;
        match_count <= e_cnt;
      end else if (match_ready) begin
        match_valid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_repeat_matcher.sv
// tb_repeat_matcher: directed checks of repeat_matcher with PATTERN "ab", MIN_REP 2, MAX_REP 3.
module tb_repeat_matcher;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic in_valid = 1'b0;
  logic [7:0] in_char = 8'h0;
  logic in_last = 1'b0;
  logic in_ready;
  logic match_valid;
  logic match_ready = 1'b1;
  logic [31:0] match_start, match_end;
  logic [1:0] match_count;
  int checks = 0;
  int errors = 0;

  repeat_matcher #(.CHAR_W(8), .PAT_LEN(2), .PATTERN(16'h6261), .MIN_REP(2), .MAX_REP(3), .POS_W(32)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_char(in_char), .in_last(in_last),
    .in_ready(in_ready), .match_valid(match_valid), .match_ready(match_ready),
    .match_start(match_start), .match_end(match_end), .match_count(match_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [7:0] c, input logic l);
    int n = 0;
    in_valid = 1'b1;
    in_char = c;
    in_last = l;
    while (!in_ready && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (!in_ready) check("send_timeout", 0, 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last = 1'b0;
  endtask

  task automatic check_report(input string tag, input logic [31:0] s, input logic [31:0] e, input logic [1:0] c);
    check({tag, "_valid"}, match_valid, 1);
    check({tag, "_start"}, match_start, s);
    check({tag, "_end"}, match_end, e);
    check({tag, "_count"}, match_count, c);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", in_ready, 0);
    check("rst_valid", match_valid, 0);
    check("rst_start", match_start, 0);
    check("rst_end", match_end, 0);
    check("rst_count", match_count, 0);
    reset = 1'b0;
    #1;
    check("post_rst_in_ready", in_ready, 1);

    // "xababz" last on z
    send("x", 0); check("t1_x", match_valid, 0);
    send("a", 0); check("t1_a1", match_valid, 0);
    send("b", 0); check("t1_b2", match_valid, 0);
    send("a", 0); check("t1_a3", match_valid, 0);
    send("b", 0); check("t1_b4", match_valid, 0);
    send("z", 1);
    check_report("t1", 1, 4, 2);

    // "abx" last: no report
    send("a", 0); check("t2_a", match_valid, 0);
    send("b", 0); check("t2_b", match_valid, 0);
    send("x", 1); check("t2_x", match_valid, 0);

    // "abababab": MAX_REP report at pos 5, trailing "ab" dropped
    send("a", 0); send("b", 0); send("a", 0); send("b", 0); send("a", 0);
    check("t3_pre", match_valid, 0);
    send("b", 0);
    check_report("t3", 0, 5, 3);
    send("a", 0); check("t3_a6", match_valid, 0);
    send("b", 1); check("t3_b7", match_valid, 0);

    // "aabab" with backpressure on the resulting report
    send("a", 0); send("a", 0); send("b", 0); send("a", 0);
    check("t4_pre", match_valid, 0);
    match_ready = 1'b0;
    send("b", 1);
    check_report("t4", 1, 4, 2);
    in_valid = 1'b1;
    in_char = "a";
    for (int i = 0; i < 3; i++) begin
      check("bp_in_ready", in_ready, 0);
      check_report("bp_hold", 1, 4, 2);
      @(posedge clk);
      #1;
    end
    match_ready = 1'b1;
    #1;
    check("bp_release_ready", in_ready, 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    check("bp_cleared", match_valid, 0);
    send("b", 0); send("a", 0); send("b", 1);
    check_report("bp_resume", 0, 3, 2);

    // "ABab" last on pos 3
    send("A", 0); send("B", 0); send("a", 0); send("b", 1);
`ifdef REPEAT_MATCHER_CASE_FOLD_EN
    check_report("fold", 0, 3, 2);
`else
    check("nofold_valid", match_valid, 0);
`endif

    // reset mid-run after "aba"
    send("a", 0); send("b", 0); send("a", 0);
    check("t6_pre", match_valid, 0);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("t6_rst_ready", in_ready, 0);
    check("t6_rst_valid", match_valid, 0);
    reset = 1'b0;
    #1;
    check("t6_ready", in_ready, 1);
    send("a", 0); send("b", 0); send("a", 0);
    check("t6_mid", match_valid, 0);
    send("b", 1);
    check_report("t6", 0, 3, 2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
